// File: rtl/conv_pkg.sv
// rtl/conv_pkg.sv - shared widths, FSM state type and saturation helper for conv_mac5
package conv_pkg;
  localparam int DATA_W = 16;
  localparam int KTAPS  = 5;
  localparam int ACC_W  = 35;
  localparam int ADDR_W = 3;
  localparam int PROD_W = 2 * DATA_W;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MAC  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic logic [DATA_W-1:0] sat_to_data(input logic signed [ACC_W-1:0] v);
    if (v > ACC_W'(32'sd32767))
      return 16'h7FFF;
    else if (v < ACC_W'(-32'sd32768))
      return 16'h8000;
    else
      return v[DATA_W-1:0];
  endfunction
endpackage

// File: rtl/conv_window_shift.sv
// rtl/conv_window_shift.sv - 5-deep sample window (tap 0 newest) with saturating fill count
module conv_window_shift
  import conv_pkg::*;
(
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           clear,
  input  logic                           shift_en,
  input  logic [DATA_W-1:0]              din,
  output logic [KTAPS-1:0][DATA_W-1:0]   taps,
  output logic [2:0]                     fill
);
  logic [KTAPS-1:0][DATA_W-1:0] taps_q, taps_d;
  logic [2:0]                   fill_q, fill_d;

  always_comb begin
    taps_d = taps_q;
    fill_d = fill_q;
    if (clear) begin
      taps_d = '0;
      fill_d = '0;
    end else if (shift_en) begin
      taps_d = {taps_q[KTAPS-2:0], din};
      fill_d = (fill_q == 3'(KTAPS)) ? fill_q : fill_q + 3'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      taps_q <= '0;
      fill_q <= '0;
    end else begin
      taps_q <= taps_d;
      fill_q <= fill_d;
    end
  end

  assign taps = taps_q;
  assign fill = fill_q;
endmodule

// File: rtl/conv_mac5.sv
// rtl/conv_mac5.sv - sliding 5-tap Q-format convolution MAC reading weights from an external register file
// CONV_SAT_EN: saturate the shifted result to 16 bits instead of wrapping.
module conv_mac5
  import conv_pkg::*;
#(
  parameter int FRAC_BITS = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              w_en,
  output logic              w_rw_mode,
  output logic [ADDR_W-1:0] w_addr,
  input  logic [DATA_W-1:0] w_data,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic              busy
);
  state_e                     state_q, state_d;
  logic [2:0]                 cnt_q, cnt_d;
  logic signed [ACC_W-1:0]    acc_q, acc_d;
  logic                       out_valid_q, out_valid_d;
  logic [DATA_W-1:0]          out_data_q, out_data_d;

  logic [KTAPS-1:0][DATA_W-1:0] taps;
  logic [2:0]                   fill;
  logic                         accept;
  logic [2:0]                   tap_idx;
  logic signed [DATA_W-1:0]     x_sel;
  logic signed [DATA_W-1:0]     w_sel;
  logic signed [PROD_W-1:0]     prod;
  logic signed [ACC_W-1:0]      acc_sum;
  logic [DATA_W-1:0]            result;

  assign in_ready  = rst_n && (state_q == ST_IDLE);
  assign accept    = in_valid && in_ready && !clear;
  assign w_rw_mode = 1'b1;
  assign w_en      = (state_q == ST_MAC) && (cnt_q < 3'(KTAPS));
  assign w_addr    = w_en ? cnt_q : '0;
  assign busy      = (state_q != ST_IDLE);
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

  conv_window_shift u_window (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (clear),
    .shift_en (accept),
    .din      (in_data),
    .taps     (taps),
    .fill     (fill)
  );

  // w_data seen while cnt_q = k answers the address issued at k-1, so it pairs with tap k-1
  assign tap_idx = (cnt_q == 3'd0) ? 3'd0 : cnt_q - 3'd1;
  assign x_sel   = taps[tap_idx];
  assign w_sel   = w_data;
  assign prod    = PROD_W'(x_sel) * PROD_W'(w_sel);
  assign acc_sum = acc_q + ACC_W'(prod);

`ifdef CONV_SAT_EN
  assign result = sat_to_data(acc_sum >>> FRAC_BITS);
`else
  assign result = DATA_W'(acc_sum >>> FRAC_BITS);
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    if (clear) begin
      state_d     = ST_IDLE;
      cnt_d       = '0;
      acc_d       = '0;
      out_valid_d = 1'b0;
      out_data_d  = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept && (fill >= 3'(KTAPS - 1))) begin
            state_d = ST_MAC;
            cnt_d   = '0;
            acc_d   = '0;
          end
        end
        ST_MAC: begin
          cnt_d = cnt_q + 3'd1;
          if (cnt_q != 3'd0) acc_d = acc_sum;
          if (cnt_q == 3'(KTAPS)) begin
            state_d     = ST_DONE;
            cnt_d       = '0;
            out_valid_d = 1'b1;
            out_data_d  = result;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            state_d     = ST_IDLE;
            out_valid_d = 1'b0;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      acc_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end
endmodule

// File: tb/tb_conv_mac5.sv
// tb/tb_conv_mac5.sv - directed self-checking bench for conv_mac5
module tb_conv_mac5;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        clear;
  logic        in_valid;
  logic [15:0] in_data;
  logic        in_ready;
  logic        w_en;
  logic        w_rw_mode;
  logic [2:0]  w_addr;
  logic [15:0] w_data;
  logic        out_valid;
  logic [15:0] out_data;
  logic        out_ready;
  logic        busy;

  logic [15:0] wmem [5];
  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  // external weight register file: data appears one edge after the address
  always @(posedge clk) begin
    if (w_en) w_data <= wmem[w_addr];
  end

  conv_mac5 #(.FRAC_BITS(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .w_en      (w_en),
    .w_rw_mode (w_rw_mode),
    .w_addr    (w_addr),
    .w_data    (w_data),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .busy      (busy)
  );

  task automatic set_weights(input logic [15:0] w);
    for (int i = 0; i < 5; i++) wmem[i] = w;
  endtask

  task automatic send(input logic [15:0] d);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int n);
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  task automatic consume();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic pulse_clear();
    @(negedge clk);
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; w_data = '0;
    set_weights(16'h0100);
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL reset_in_ready actual=%b required=0", in_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid actual=%b required=0", out_valid); end
    n_cmp++; if (out_data !== 16'h0000) begin n_bad++; $display("FAIL reset_out_data actual=%h required=0000", out_data); end
    n_cmp++; if (w_en !== 1'b0 || w_addr !== 3'd0) begin n_bad++; $display("FAIL reset_w_en_addr actual=%b/%0d required=0/0", w_en, w_addr); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy actual=%b required=0", busy); end
    n_cmp++; if (w_rw_mode !== 1'b1) begin n_bad++; $display("FAIL reset_w_rw_mode actual=%b required=1", w_rw_mode); end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL post_reset_in_ready actual=%b required=1", in_ready); end
  endtask

  task automatic test_basic();
    set_weights(16'h0100);
    for (int i = 1; i <= 4; i++) begin
      send(16'(i * 256));
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL fill_busy_%0d actual=%b required=0", i, busy); end
    end
    send(16'h0500);
    n_cmp++; if (w_en !== 1'b1 || w_addr !== 3'd0) begin n_bad++; $display("FAIL mac_addr_0 actual=%b/%0d required=1/0", w_en, w_addr); end
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk);
      #1;
      if (k <= 4) begin
        n_cmp++; if (w_en !== 1'b1 || w_addr !== 3'(k)) begin n_bad++; $display("FAIL mac_addr_%0d actual=%b/%0d required=1/%0d", k, w_en, w_addr, k); end
      end else begin
        n_cmp++; if (w_en !== 1'b0) begin n_bad++; $display("FAIL mac_w_en_low_%0d actual=%b required=0", k, w_en); end
      end
      n_cmp++; if (out_valid !== (k == 6)) begin n_bad++; $display("FAIL latency_edge_%0d actual=%b required=%b", k, out_valid, (k == 6)); end
    end
    n_cmp++; if (out_data !== 16'h0F00) begin n_bad++; $display("FAIL basic_data actual=%h required=0F00", out_data); end
    consume();
    n_cmp++; if (out_valid !== 1'b0 || busy !== 1'b0) begin n_bad++; $display("FAIL basic_handshake actual=%b/%b required=0/0", out_valid, busy); end
  endtask

  task automatic test_backpressure();
    int n;
    send(16'h0600);
    wait_out(n);
    n_cmp++; if (n !== 6) begin n_bad++; $display("FAIL slide_latency actual=%0d required=6", n); end
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = 16'h7777;
      n_cmp++; if (out_valid !== 1'b1 || out_data !== 16'h1400 || in_ready !== 1'b0 || w_en !== 1'b0) begin
        n_bad++; $display("FAIL hold_%0d actual=v%b d%h r%b w%b required=v1 d1400 r0 w0", c, out_valid, out_data, in_ready, w_en);
      end
    end
    in_valid = 1'b0;
    consume();
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL hold_release actual=%b required=0", out_valid); end
  endtask

  task automatic test_back_to_back();
    int n;
    send(16'h0700);
    wait_out(n);
    n_cmp++; if (n !== 6 || out_data !== 16'h1900) begin n_bad++; $display("FAIL b2b_first actual=%0d/%h required=6/1900", n, out_data); end
    consume();
    send(16'h0800);
    wait_out(n);
    n_cmp++; if (n !== 6 || out_data !== 16'h1E00) begin n_bad++; $display("FAIL b2b_second actual=%0d/%h required=6/1E00", n, out_data); end
    consume();
  endtask

  task automatic test_neg_weights();
    int n;
    pulse_clear();
    set_weights(16'hFF00);
    for (int i = 1; i <= 5; i++) send(16'(i * 256));
    wait_out(n);
    n_cmp++; if (n !== 6 || out_data !== 16'hF100) begin n_bad++; $display("FAIL neg_weights actual=%0d/%h required=6/F100", n, out_data); end
    consume();
  endtask

  task automatic test_sat();
    int n;
    logic [15:0] exp_v;
`ifdef CONV_SAT_EN
    exp_v = 16'h7FFF;
`else
    exp_v = 16'hFB00;
`endif
    pulse_clear();
    set_weights(16'h7FFF);
    for (int i = 0; i < 5; i++) send(16'h7FFF);
    wait_out(n);
    n_cmp++; if (n !== 6 || out_data !== exp_v) begin n_bad++; $display("FAIL max_operands actual=%0d/%h required=6/%h", n, out_data, exp_v); end
    consume();
  endtask

  task automatic test_clear_mid_mac();
    int n;
    pulse_clear();
    set_weights(16'h0100);
    for (int i = 1; i <= 5; i++) send(16'h0900);
    repeat (2) @(posedge clk);
    #1;
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
    n_cmp++; if (busy !== 1'b0 || w_en !== 1'b0 || in_ready !== 1'b1) begin n_bad++; $display("FAIL clear_state actual=b%b w%b r%b required=b0 w0 r1", busy, w_en, in_ready); end
    @(negedge clk);
    clear = 1'b1; in_valid = 1'b1; in_data = 16'h0A00;
    @(posedge clk);
    #1;
    clear = 1'b0; in_valid = 1'b0;
    for (int i = 1; i <= 4; i++) send(16'(i * 256));
    for (int c = 0; c < 8; c++) begin
      @(posedge clk);
      #1;
      n_cmp++; if (out_valid !== 1'b0 || busy !== 1'b0) begin n_bad++; $display("FAIL clear_quiet_%0d actual=%b/%b required=0/0", c, out_valid, busy); end
    end
    send(16'h0500);
    wait_out(n);
    n_cmp++; if (n !== 6 || out_data !== 16'h0F00) begin n_bad++; $display("FAIL clear_refill actual=%0d/%h required=6/0F00", n, out_data); end
    consume();
  endtask

  task automatic test_reset_mid_mac();
    int n;
    for (int i = 1; i <= 5; i++) send(16'h0900);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (busy !== 1'b0 || w_en !== 1'b0 || in_ready !== 1'b0 || out_valid !== 1'b0) begin
      n_bad++; $display("FAIL rst_mid_state actual=b%b w%b r%b v%b required=b0 w0 r0 v0", busy, w_en, in_ready, out_valid);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 1; i <= 4; i++) send(16'(i * 256));
    for (int c = 0; c < 8; c++) begin
      @(posedge clk);
      #1;
      n_cmp++; if (out_valid !== 1'b0 || busy !== 1'b0) begin n_bad++; $display("FAIL rst_quiet_%0d actual=%b/%b required=0/0", c, out_valid, busy); end
    end
    send(16'h0500);
    wait_out(n);
    n_cmp++; if (n !== 6 || out_data !== 16'h0F00) begin n_bad++; $display("FAIL rst_refill actual=%0d/%h required=6/0F00", n, out_data); end
    consume();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_back_to_back();
    test_neg_weights();
    test_sat();
    test_clear_mid_mac();
    test_reset_mid_mac();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
